// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//
// Contents:
//   uart_rx_state_t   - receiver FSM state encoding
//   CLK_HZ, BAUD      - system clock and line rate
//   CLKS_PER_BIT_DEF  - default clk cycles per bit period
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int CLK_HZ           = 100_000_000;
    localparam int BAUD             = 115200;
    localparam int CLKS_PER_BIT_DEF = CLK_HZ / BAUD;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for an asynchronous single-bit input.
//
// Parameters:
//   RESET_VAL - value both stages take during reset (use the idle level of
//               the input so that no false edge is seen when reset is released)
// Ports:
//   clk       - destination clock
//   rst       - synchronous reset, active-high
//   async_sig - asynchronous input
//   sync_sig  - input re-timed to clk, two cycles late
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_sig,
    output logic sync_sig
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= RESET_VAL;
            sync_sig <= RESET_VAL;
        end else begin
            meta     <= async_sig;
            sync_sig <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1-style UART receiver: deserializes frames from the rx line into a
// single-entry valid/ready holding register, flagging framing errors and
// overruns.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per bit period (4..65535)
//   DATA_BITS    - data bits per frame, LSB first (5..8)
// Ports:
//   clk       - system clock
//   rst       - synchronous reset, active-high
//   rx        - asynchronous serial input, idle high
//   rx_ready  - consumer accepts rx_data when high together with rx_valid
//   rx_data   - received byte, stable while rx_valid is high
//   rx_valid  - holding register contains an unread byte
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   overrun   - sticky: a byte completed while the holding register was full
//   busy      - receiver is somewhere inside a frame
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] WRAP_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t       state, state_next;
    logic [CNT_W-1:0]     baud_cnt, baud_next;
    logic [IDX_W-1:0]     bit_idx, idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 valid_next;
    logic                 ferr_next;
    logic                 overrun_next;

    // The idle line is high, so the synchronizer resets high to avoid
    // mistaking reset release for a start edge.
    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .async_sig (rx),
        .sync_sig  (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
            rx_data   <= data_next;
            rx_valid  <= valid_next;
            frame_err <= ferr_next;
            overrun   <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state;
        baud_next    = baud_cnt;
        idx_next     = bit_idx;
        shift_next   = shift_reg;
        data_next    = rx_data;
        valid_next   = rx_valid;
        ferr_next    = 1'b0;
        overrun_next = overrun;

        // A handshake empties the holding register; a byte completing in the
        // same cycle overrides this below and keeps rx_valid high.
        if (rx_valid && rx_ready) begin
            valid_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    baud_next  = '0;
                    state_next = START;
                end
            end

            // Re-check the line half a bit later so that short low glitches
            // are rejected and all later samples land mid-bit.
            START: begin
                if (baud_cnt == HALF_CNT) begin
                    if (!rx_s) begin
                        baud_next  = '0;
                        idx_next   = '0;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end

            // Shifting in from the top leaves the first (LSB) bit at bit 0
            // once all DATA_BITS samples have been taken.
            DATA: begin
                if (baud_cnt == WRAP_CNT) begin
                    baud_next  = '0;
                    shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                    idx_next   = bit_idx + IDX_W'(1);
                    if (bit_idx == LAST_IDX) begin
                        state_next = STOP;
                    end
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end

            // Decide at mid stop bit and return to IDLE at once, so a start
            // bit immediately following the stop bit is still caught.
            STOP: begin
                if (baud_cnt == WRAP_CNT) begin
                    baud_next  = '0;
                    state_next = IDLE;
                    if (rx_s) begin
                        if (!rx_valid || rx_ready) begin
                            data_next  = shift_reg;
                            valid_next = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
                    end else begin
                        ferr_next = 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed self-checking bench for uart_rx_deserializer with
// CLKS_PER_BIT=16 and DATA_BITS=8.
module tb_uart_rx_deserializer;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total;
    int bad;
    logic ready_base;

    int         valid_cycles;
    int         valid_low_cycles;
    int         ferr_cycles;
    logic [7:0] last_data;

    int v0, vl0, f0;

    uart_rx_deserializer #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output activity is tallied on the falling edge, away from the
    // active edge, and compared as deltas by the main sequence.
    initial begin
        valid_cycles     = 0;
        valid_low_cycles = 0;
        ferr_cycles      = 0;
        last_data        = 8'h00;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                valid_cycles = valid_cycles + 1;
                last_data    = rx_data;
            end else begin
                valid_low_cycles = valid_low_cycles + 1;
            end
            if (frame_err) begin
                ferr_cycles = ferr_cycles + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total = total + 1;
        assert (observed === expected)
        else begin
            bad = bad + 1;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame (start, 8 data bits LSB first, stop) for n_cycles
    // clock cycles starting just after an active edge. rx_ready follows
    // ready_base except on cycle pulse_at, where it is forced high.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                                 input int pulse_at, input int n_cycles);
        int idx;
        for (int c = 0; c < n_cycles; c++) begin
            idx = c / CPB;
            if (idx == 0) begin
                rx = 1'b0;
            end else if (idx <= 8) begin
                rx = data[idx-1];
            end else begin
                rx = stop_val;
            end
            rx_ready = (c == pulse_at) ? 1'b1 : ready_base;
            @(posedge clk);
            #1;
        end
        rx_ready = ready_base;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        ready_base = 1'b1;
        rst        = 1'b1;
        rx         = 1'b1;
        rx_ready   = 1'b1;

        waitCycles(3);
        $display("[TB] reset state");
        checkOutput("reset_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_data", {24'd0, rx_data}, 32'd0);
        rst = 1'b0;
        waitCycles(5);

        // Single clean frame with the consumer always ready.
        $display("[TB] single frame 0xA5");
        v0 = valid_cycles;
        f0 = ferr_cycles;
        applyStimulus(8'hA5, 1'b1, -1, 10 * CPB);
        rx = 1'b1;
        waitCycles(20);
        checkOutput("a5_valid_cycles", valid_cycles - v0, 32'd1);
        checkOutput("a5_data", {24'd0, last_data}, 32'hA5);
        checkOutput("a5_frame_err", ferr_cycles - f0, 32'd0);
        checkOutput("a5_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("a5_busy", {31'd0, busy}, 32'd0);

        // Back-to-back frames with nobody reading: second byte overruns.
        $display("[TB] back-to-back 0x00 then 0xFF, not ready");
        ready_base = 1'b0;
        rx_ready   = 1'b0;
        f0 = ferr_cycles;
        applyStimulus(8'h00, 1'b1, -1, 10 * CPB);
        checkOutput("b2b_first_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("b2b_first_overrun", {31'd0, overrun}, 32'd0);
        applyStimulus(8'hFF, 1'b1, -1, 10 * CPB);
        rx = 1'b1;
        waitCycles(20);
        checkOutput("b2b_overrun", {31'd0, overrun}, 32'd1);
        checkOutput("b2b_data_kept", {24'd0, rx_data}, 32'h00);
        checkOutput("b2b_valid_kept", {31'd0, rx_valid}, 32'd1);
        checkOutput("b2b_frame_err", ferr_cycles - f0, 32'd0);

        // Overrun is sticky until reset.
        rst = 1'b1;
        waitCycles(1);
        checkOutput("rst1_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("rst1_valid", {31'd0, rx_valid}, 32'd0);
        rst = 1'b0;
        ready_base = 1'b1;
        rx_ready   = 1'b1;
        waitCycles(5);

        // Stop bit low: one-cycle frame_err and nothing delivered.
        $display("[TB] framing error 0x3C");
        v0 = valid_cycles;
        f0 = ferr_cycles;
        applyStimulus(8'h3C, 1'b0, -1, 10 * CPB);
        rx = 1'b1;
        waitCycles(30);
        checkOutput("ferr_pulse_cycles", ferr_cycles - f0, 32'd1);
        checkOutput("ferr_valid_cycles", valid_cycles - v0, 32'd0);
        checkOutput("ferr_busy", {31'd0, busy}, 32'd0);
        checkOutput("ferr_overrun", {31'd0, overrun}, 32'd0);

        // Five-cycle low glitch: START is entered then abandoned.
        $display("[TB] 5-cycle glitch");
        v0 = valid_cycles;
        f0 = ferr_cycles;
        rx = 1'b0;
        waitCycles(5);
        checkOutput("glitch_busy_start", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        waitCycles(30);
        checkOutput("glitch_busy_end", {31'd0, busy}, 32'd0);
        checkOutput("glitch_valid_cycles", valid_cycles - v0, 32'd0);
        checkOutput("glitch_frame_err", ferr_cycles - f0, 32'd0);

        // Handshake in the same cycle the second byte completes.
        $display("[TB] simultaneous consume and load");
        ready_base = 1'b0;
        rx_ready   = 1'b0;
        applyStimulus(8'h11, 1'b1, -1, 10 * CPB);
        rx = 1'b1;
        waitCycles(10);
        checkOutput("hs_first_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("hs_first_data", {24'd0, rx_data}, 32'h11);
        vl0 = valid_low_cycles;
        applyStimulus(8'h22, 1'b1, 154, 10 * CPB);
        rx = 1'b1;
        checkOutput("hs_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("hs_data", {24'd0, rx_data}, 32'h22);
        checkOutput("hs_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("hs_valid_never_low", valid_low_cycles - vl0, 32'd0);

        // Reset in the middle of data bit 4 of 0x81, then a clean 0x42.
        $display("[TB] reset mid-frame");
        applyStimulus(8'h81, 1'b1, -1, 5 * CPB + CPB / 2);
        rst        = 1'b1;
        rx         = 1'b1;
        ready_base = 1'b1;
        rx_ready   = 1'b1;
        waitCycles(1);
        checkOutput("midrst_data", {24'd0, rx_data}, 32'd0);
        checkOutput("midrst_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("midrst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        v0 = valid_cycles;
        f0 = ferr_cycles;
        waitCycles(40);
        applyStimulus(8'h42, 1'b1, -1, 10 * CPB);
        rx = 1'b1;
        waitCycles(20);
        checkOutput("after_rst_valid_cycles", valid_cycles - v0, 32'd1);
        checkOutput("after_rst_data", {24'd0, last_data}, 32'h42);
        checkOutput("after_rst_frame_err", ferr_cycles - f0, 32'd0);
        checkOutput("after_rst_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
